// File: rtl/axi4_arb_pkg.sv
// Shared types and sizing helpers for the AXI4 write/read arbiters.
package axi4_arb_pkg;

    localparam int unsigned AXI4_LEN_WIDTH = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module axi4_rr_picker
    import axi4_arb_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_any
);

    always_comb begin
        int unsigned    cand;
        logic [IDW-1:0] cand_idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand     = (32'(ptr) + i) % N;
            cand_idx = IDW'(cand);
            if (!gnt_any && req[cand_idx]) begin
                gnt_any              = 1'b1;
                gnt_idx              = cand_idx;
                gnt_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_wr_addr_arbiter.sv
// Round-robin AW+W arbiter for one slave port; grant held until AW and WLAST
// handshakes both complete. Flags burst-length errors and long-held grants.
module axi4_wr_addr_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 8,
    parameter int unsigned LEN_WIDTH   = AXI4_LEN_WIDTH,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_MASTERS-1:0]           m_awvalid,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0] m_awlen,
    output logic [NUM_MASTERS-1:0]           m_awready,
    input  logic [NUM_MASTERS-1:0]           m_wvalid,
    input  logic [NUM_MASTERS-1:0]           m_wlast,
    output logic [NUM_MASTERS-1:0]           m_wready,
    output logic                             s_awvalid,
    input  logic                             s_awready,
    output logic                             s_wvalid,
    output logic                             s_wlast,
    input  logic                             s_wready,
    output logic                             grant_valid,
    output logic [$clog2(NUM_MASTERS)-1:0]   grant_id,
    output logic                             len_err,
    output logic                             timeout
);

    localparam int unsigned IDW = id_width(NUM_MASTERS);
    localparam int unsigned HCW = $clog2(TIMEOUT + 1);
    localparam logic [LEN_WIDTH:0] BEAT_MAX = {1'b1, {LEN_WIDTH{1'b0}}};

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [LEN_WIDTH:0] beat_cnt_q, beat_cnt_d;
    logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
    logic               len_err_q, len_err_d;
    logic               timeout_q, timeout_d;
    logic               cool_q, cool_d;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDW-1:0]         pick_idx;
    logic                   pick_any;
    logic [LEN_WIDTH-1:0]   pick_len;
    logic                   aw_hs, wlast_hs;

    axi4_rr_picker #(
        .N   (NUM_MASTERS),
        .IDW (IDW)
    ) u_picker (
        .req        (m_awvalid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .gnt_any    (pick_any)
    );

    always_comb begin
        pick_len = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (pick_onehot[i]) pick_len |= m_awlen[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        len_d      = len_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        beat_cnt_d = beat_cnt_q;
        hold_cnt_d = hold_cnt_q;
        len_err_d  = 1'b0;
        timeout_d  = 1'b0;
        cool_d     = 1'b0;
        m_awready  = '0;
        m_wready   = '0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_wlast    = 1'b0;
        aw_hs      = 1'b0;
        wlast_hs   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // The IDLE cycle right after a release does not arbitrate,
                // giving the 3-cycle arb/handshake/idle transaction rhythm.
                if (pick_any && !cool_q) begin
                    state_d    = ARB_BUSY;
                    grant_id_d = pick_idx;
                    rr_ptr_d   = (pick_idx == IDW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
                    len_d      = pick_len;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    beat_cnt_d = '0;
                    hold_cnt_d = HCW'(1);
                end
            end
            ARB_BUSY: begin
                if (!aw_done_q) begin
                    s_awvalid             = m_awvalid[grant_id_q];
                    m_awready[grant_id_q] = s_awready;
                    aw_hs                 = s_awvalid && s_awready;
                end
                if (!w_done_q) begin
                    s_wvalid             = m_wvalid[grant_id_q];
                    s_wlast              = m_wlast[grant_id_q];
                    m_wready[grant_id_q] = s_wready;
                    if (s_wvalid && s_wready) begin
                        if (beat_cnt_q != BEAT_MAX) beat_cnt_d = beat_cnt_q + 1'b1;
                        if (s_wlast) begin
                            wlast_hs  = 1'b1;
                            len_err_d = (beat_cnt_q != {1'b0, len_q});
                        end
                    end
                end
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || wlast_hs;
                if (hold_cnt_q != HCW'(TIMEOUT)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    timeout_d  = (hold_cnt_q == HCW'(TIMEOUT - 1));
                end
                if (aw_done_d && w_done_d) begin
                    state_d    = ARB_IDLE;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    beat_cnt_d = '0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b0;
                    cool_d     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            beat_cnt_q <= '0;
            hold_cnt_q <= '0;
            len_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cool_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            beat_cnt_q <= beat_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            len_err_q  <= len_err_d;
            timeout_q  <= timeout_d;
            cool_q     <= cool_d;
        end
    end

    assign grant_valid = (state_q == ARB_BUSY);
    assign grant_id    = grant_id_q;
    assign len_err     = len_err_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_axi4_wr_addr_arbiter.sv
// Directed bench for axi4_wr_addr_arbiter: vector table for round robin plus
// hand-written multi-cycle sequences (W before AW, same-cycle end, len_err, timeout).
module tb_axi4_wr_addr_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  m_awvalid;
    logic [63:0] m_awlen;
    logic [7:0]  m_awready;
    logic [7:0]  m_wvalid;
    logic [7:0]  m_wlast;
    logic [7:0]  m_wready;
    logic        s_awvalid;
    logic        s_awready;
    logic        s_wvalid;
    logic        s_wlast;
    logic        s_wready;
    logic        grant_valid;
    logic [2:0]  grant_id;
    logic        len_err;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    axi4_wr_addr_arbiter #(
        .NUM_MASTERS (8),
        .LEN_WIDTH   (8),
        .TIMEOUT     (16)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .m_awvalid   (m_awvalid),
        .m_awlen     (m_awlen),
        .m_awready   (m_awready),
        .m_wvalid    (m_wvalid),
        .m_wlast     (m_wlast),
        .m_wready    (m_wready),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wvalid    (s_wvalid),
        .s_wlast     (s_wlast),
        .s_wready    (s_wready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .len_err     (len_err),
        .timeout     (timeout)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] av, wv, wl;
        logic       sa, sw;
        logic       gv;
        logic [2:0] gid;
        logic       sav, swv, swl;
        logic [7:0] ar, wr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] av, wv, wl, input logic sa, sw, gv,
                       input logic [2:0] gid, input logic sav, swv, swl,
                       input logic [7:0] ar, wr);
        vec_t v;
        v = '{av, wv, wl, sa, sw, gv, gid, sav, swv, swl, ar, wr};
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_grant(input logic [2:0] exp_id);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge aclk);
            if (grant_valid === 1'b1) seen = 1'b1;
            else next_cycle();
        end
        check("grant_seen", 32'(seen), 32'd1);
        check("grant_id", 32'(grant_id), 32'(exp_id));
    endtask

    task automatic idle_inputs();
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_awlen = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        m_awvalid = 8'hFF; m_wvalid = 8'hFF; m_wlast = 8'hFF; m_awlen = '0;
        s_awready = 1'b1; s_wready = 1'b1;

        // Reset held with every master requesting
        for (int r = 0; r < 2; r++) begin
            next_cycle();
            @(negedge aclk);
            check($sformatf("rst%0d_gv", r), 32'(grant_valid), 0);
            check($sformatf("rst%0d_gid", r), 32'(grant_id), 0);
            check($sformatf("rst%0d_awready", r), 32'(m_awready), 0);
            check($sformatf("rst%0d_wready", r), 32'(m_wready), 0);
            check($sformatf("rst%0d_sawvalid", r), 32'(s_awvalid), 0);
            check($sformatf("rst%0d_swvalid", r), 32'(s_wvalid), 0);
            check($sformatf("rst%0d_flags", r), {30'd0, len_err, timeout}, 0);
        end
        next_cycle();
        aresetn = 1'b1;

        //   av     wv     wl     sa sw gv gid sav swv swl ar     wr
        add(8'hFF, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        add(8'hFF, 8'h01, 8'h01, 1, 1, 1, 0, 1, 1, 1, 8'h01, 8'h01);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 1, 1, 1, 1, 1, 8'h02, 8'h02);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 1, 3, 1, 1, 1, 8'h08, 8'h08);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 3, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 3, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 1, 6, 1, 1, 1, 8'h40, 8'h40);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 6, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 6, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 1, 1, 1, 1, 1, 8'h02, 8'h02);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        add(8'h4A, 8'h4A, 8'h4A, 1, 1, 1, 3, 1, 1, 1, 8'h08, 8'h08);
        add(8'h00, 8'h00, 8'h00, 1, 1, 0, 3, 0, 0, 0, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h00, 1, 1, 0, 3, 0, 0, 0, 8'h00, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            m_awvalid = vecs[i].av; m_wvalid = vecs[i].wv; m_wlast = vecs[i].wl;
            s_awready = vecs[i].sa; s_wready = vecs[i].sw;
            @(negedge aclk);
            check($sformatf("v%0d_gv", i), 32'(grant_valid), 32'(vecs[i].gv));
            check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].gid));
            check($sformatf("v%0d_sawvalid", i), 32'(s_awvalid), 32'(vecs[i].sav));
            check($sformatf("v%0d_swvalid", i), 32'(s_wvalid), 32'(vecs[i].swv));
            check($sformatf("v%0d_swlast", i), 32'(s_wlast), 32'(vecs[i].swl));
            check($sformatf("v%0d_awready", i), 32'(m_awready), 32'(vecs[i].ar));
            check($sformatf("v%0d_wready", i), 32'(m_wready), 32'(vecs[i].wr));
            check($sformatf("v%0d_lenerr", i), 32'(len_err), 0);
            next_cycle();
        end

        // W before AW: master 2, awlen=3, slave withholds AW ready for 10 cycles
        idle_inputs();
        m_awvalid = 8'h04; m_awlen[2*8 +: 8] = 8'd3; m_wvalid = 8'h04;
        s_awready = 1'b0; s_wready = 1'b1;
        wait_grant(3'd2);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin
                next_cycle();
                m_wlast  = (c == 4) ? 8'h04 : 8'h00;
                m_wvalid = (c <= 4) ? 8'h04 : 8'h00;
                @(negedge aclk);
            end
            check($sformatf("wa_c%0d_gv", c), 32'(grant_valid), 1);
            check($sformatf("wa_c%0d_sawvalid", c), 32'(s_awvalid), 1);
            check($sformatf("wa_c%0d_awready", c), 32'(m_awready), 0);
            check($sformatf("wa_c%0d_wready", c), 32'(m_wready), (c <= 4) ? 32'h04 : 32'h00);
            check($sformatf("wa_c%0d_swvalid", c), 32'(s_wvalid), (c <= 4) ? 32'd1 : 32'd0);
            check($sformatf("wa_c%0d_lenerr", c), 32'(len_err), 0);
        end
        next_cycle();
        s_awready = 1'b1;
        @(negedge aclk);
        check("wa_aw_hs_awready", 32'(m_awready), 32'h04);
        next_cycle();
        m_awvalid = '0;
        @(negedge aclk);
        check("wa_released_gv", 32'(grant_valid), 0);
        check("wa_released_lenerr", 32'(len_err), 0);
        next_cycle();

        // Same-cycle AW and WLAST completion, master 7 waiting behind master 5
        idle_inputs();
        m_awvalid = 8'hA0; m_wvalid = 8'h20; m_wlast = 8'h20;
        s_awready = 1'b1; s_wready = 1'b1;
        wait_grant(3'd5);
        check("sc_awready", 32'(m_awready), 32'h20);
        check("sc_wready", 32'(m_wready), 32'h20);
        check("sc_swlast", 32'(s_wlast), 1);
        next_cycle();
        m_awvalid = 8'h80; m_wvalid = 8'h80; m_wlast = 8'h80;
        @(negedge aclk);
        check("sc_idle_next_gv", 32'(grant_valid), 0);
        next_cycle();
        @(negedge aclk);
        check("sc_arb_gv", 32'(grant_valid), 0);
        next_cycle();
        @(negedge aclk);
        check("sc_next_gv", 32'(grant_valid), 1);
        check("sc_next_gid", 32'(grant_id), 7);
        next_cycle();
        idle_inputs();
        @(negedge aclk);
        check("sc_done_gv", 32'(grant_valid), 0);
        next_cycle();

        // Length error: awlen=3 but WLAST on beat 2
        idle_inputs();
        m_awvalid = 8'h01; m_awlen[0 +: 8] = 8'd3; m_wvalid = 8'h01;
        wait_grant(3'd0);
        check("le_beat1_wready", 32'(m_wready), 32'h01);
        next_cycle();
        m_awvalid = '0; m_wlast = 8'h01;
        @(negedge aclk);
        check("le_beat2_wready", 32'(m_wready), 32'h01);
        check("le_beat2_swlast", 32'(s_wlast), 1);
        check("le_beat2_lenerr", 32'(len_err), 0);
        next_cycle();
        m_wvalid = '0; m_wlast = '0;
        @(negedge aclk);
        check("le_pulse", 32'(len_err), 1);
        check("le_released_gv", 32'(grant_valid), 0);
        next_cycle();
        @(negedge aclk);
        check("le_pulse_end", 32'(len_err), 0);
        next_cycle();

        // awlen=0, single WLAST beat: no error
        idle_inputs();
        m_awvalid = 8'h10; m_wvalid = 8'h10; m_wlast = 8'h10;
        wait_grant(3'd4);
        check("ok_wready", 32'(m_wready), 32'h10);
        next_cycle();
        idle_inputs();
        @(negedge aclk);
        check("ok_lenerr", 32'(len_err), 0);
        check("ok_gv", 32'(grant_valid), 0);
        next_cycle();

        // Timeout with slave W stalled, then reset mid-transaction
        idle_inputs();
        m_awvalid = 8'h08; m_wvalid = 8'h08; m_wlast = 8'h08;
        s_awready = 1'b1; s_wready = 1'b0;
        wait_grant(3'd3);
        for (int n = 1; n <= 20; n++) begin
            check($sformatf("to_c%0d_timeout", n), 32'(timeout), (n == 16) ? 32'd1 : 32'd0);
            check($sformatf("to_c%0d_gv", n), 32'(grant_valid), 1);
            next_cycle();
            @(negedge aclk);
        end
        next_cycle();
        aresetn = 1'b0;
        next_cycle();
        @(negedge aclk);
        check("to_rst_gv", 32'(grant_valid), 0);
        check("to_rst_gid", 32'(grant_id), 0);
        check("to_rst_timeout", 32'(timeout), 0);
        check("to_rst_wready", 32'(m_wready), 0);
        check("to_rst_swvalid", 32'(s_wvalid), 0);
        check("to_rst_sawvalid", 32'(s_awvalid), 0);
        next_cycle();
        aresetn = 1'b1;
        idle_inputs();
        next_cycle();
        @(negedge aclk);
        check("post_rst_lenerr", 32'(len_err), 0);
        check("post_rst_gv", 32'(grant_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
